aurora_hls_nfc: RTL and testbench
=================================

Name: aurora_hls_nfc

Overview:
- Receive-side flow-control stage that consumes the 32-bit fifo_thresholds word from the configuration block (prog_full in [31:16], prog_empty in [15:0]).
- Compares RX FIFO occupancy against those thresholds with hysteresis and issues XOFF/XON native-flow-control requests to the Aurora core's NFC AXI-Stream port.
- This throttles the remote transmitter before the RX FIFO overflows.

Parameters:
- CNT_WIDTH, 32, width of the optional status counters.
- REFRESH_CYCLES, 4096, cycles spent in OFF before XOFF is re-sent; 0 disables refresh.

Ports:
- user_clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- fifo_thresholds  in  32  {prog_full[15:0], prog_empty[15:0]}; quasi-static.
- channel_up  in  1  Aurora channel-up status.
- rx_fifo_count  in  16  current RX FIFO occupancy in words.
- nfc_tvalid  out  1  NFC request valid.
- nfc_tdata  out  16  NFC request code.
- nfc_tready  in  1  core accepts the request.
- xoff_active  out  1  high while the remote is paused (SEND_XOFF handshake complete, until XON is accepted).
- config_error  out  1  thresholds are unusable (prog_empty >= prog_full).
- xoff_count  out  CNT_WIDTH  XOFF requests accepted (feature only).
- xoff_cycles  out  CNT_WIDTH  cycles spent with xoff_active high (feature only).

Behaviour:
- Reset: all outputs 0; state ON; occupancy register 0.
- Input registration: rx_fifo_count and fifo_thresholds are registered once. All decisions use the registered values, so request latency is 1 cycle from the count change to the state transition and 2 cycles to nfc_tvalid.
- config_error: registered, equals (prog_empty >= prog_full). While high, the FSM stays in or returns to ON and never raises XOFF.
- Request codes: XON = 16'h0000, XOFF = 16'h0001.
- States: ON, SEND_XOFF, OFF, SEND_XON.
- ON -> SEND_XOFF when channel_up && !config_error && count >= prog_full.
- SEND_XOFF:
  - nfc_tvalid=1, nfc_tdata=XOFF.
  - On tvalid&&tready -> OFF; xoff_active=1 from the next cycle.
- OFF:
  - -> SEND_XON when count <= prog_empty.
  - Otherwise, when the refresh timer reaches REFRESH_CYCLES-1 -> SEND_XOFF. The timer restarts and xoff_count increments again on acceptance.
- SEND_XON:
  - nfc_tvalid=1, nfc_tdata=XON.
  - On accept -> ON; xoff_active=0 next cycle.
- Counts between prog_empty and prog_full cause no transition (hysteresis).
- AXI-Stream rules:
  - tvalid, once raised, holds with stable tdata until tready.
  - If count drops to <= prog_empty while SEND_XOFF is pending, the XOFF still completes, and the FSM goes OFF then SEND_XON next cycle.
- channel_up low in any state:
  - Next cycle: state ON, nfc_tvalid=0, xoff_active=0, refresh timer cleared.
  - This is the one permitted tvalid withdrawal, because the core discards NFC when the link is down.
- Threshold equal cases: count == prog_full triggers XOFF; count == prog_empty triggers XON.
- Counters saturate at all-ones; they do not wrap.
- Refresh timer: width $clog2(REFRESH_CYCLES+1); runs only in OFF.
- Reset mid-handshake: tvalid drops immediately (asynchronous); no request is considered sent.

Optional Feature:
- Macro AURORA_HLS_NFC_STATUS_EN.
- Defined: xoff_count and xoff_cycles are implemented, saturating, and cleared only by reset.
- Undefined: both ports are tied to 0 and no counter flops are synthesized. FSM behaviour is identical either way.

Decomposition:
- Shared package/define file: NFC_XON and NFC_XOFF codes, the state encoding (2-bit localparams), and the fifo_thresholds field offsets (PROG_FULL_MSB=31, PROG_FULL_LSB=16, PROG_EMPTY_MSB=15, PROG_EMPTY_LSB=0). The configuration block and this block share these offsets.
- One natural sub-module: aurora_hls_sat_counter (parameterized width, enable, saturating), instantiated twice under the macro.

Test Plan:
- thresholds={16'd48,16'd16}, channel_up=1, count ramps 0->48, tready=1 -> nfc_tvalid rises 2 cycles after count=48 with tdata=0x0001; xoff_active=1 after accept; xoff_count=1.
- Count falls 48->17 -> no request; at count=16 -> XON request (tdata=0x0000); xoff_active=0 after accept.
- tready held 0 for 10 cycles during SEND_XOFF while count varies -> tvalid and tdata stable for all 10 cycles; exactly one acceptance.
- REFRESH_CYCLES=8, count held at 60 -> XOFF re-sent every 8 OFF cycles plus handshake; xoff_count increments each time.
- thresholds={16'd16,16'd16} -> config_error=1 one cycle later; count=100 produces no nfc_tvalid.
- channel_up drops during SEND_XOFF with tready=0 -> next cycle nfc_tvalid=0, state ON, xoff_active=0. A mid-operation reset pulse gives the same result asynchronously.

Source files
------------

// File: rtl/aurora_hls_nfc_pkg.sv
// Shared definitions for the Aurora native-flow-control path: NFC request
// codes, FSM state encoding and fifo_thresholds field offsets.
package aurora_hls_nfc_pkg;

  localparam logic [15:0] NFC_XON  = 16'h0000;
  localparam logic [15:0] NFC_XOFF = 16'h0001;

  localparam logic [1:0] ST_ON_ENC       = 2'd0;
  localparam logic [1:0] ST_SEND_XOFF_ENC = 2'd1;
  localparam logic [1:0] ST_OFF_ENC      = 2'd2;
  localparam logic [1:0] ST_SEND_XON_ENC = 2'd3;

  typedef enum logic [1:0] {
    ST_ON        = ST_ON_ENC,
    ST_SEND_XOFF = ST_SEND_XOFF_ENC,
    ST_OFF       = ST_OFF_ENC,
    ST_SEND_XON  = ST_SEND_XON_ENC
  } nfc_state_e;

  // Offsets are shared with the configuration block that packs this word.
  localparam int PROG_FULL_MSB  = 31;
  localparam int PROG_FULL_LSB  = 16;
  localparam int PROG_EMPTY_MSB = 15;
  localparam int PROG_EMPTY_LSB = 0;

  typedef struct packed {
    logic [15:0] prog_full;
    logic [15:0] prog_empty;
  } nfc_thr_t;

endpackage

// File: rtl/aurora_hls_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module aurora_hls_sat_counter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [DATA_W-1:0] count
);

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (&v) ? v : v + DATA_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/aurora_hls_nfc.sv
// RX-side native flow control: issues XOFF/XON on the Aurora NFC port with
// hysteresis on FIFO occupancy. Define AURORA_HLS_NFC_STATUS_EN for counters.
module aurora_hls_nfc
  import aurora_hls_nfc_pkg::*;
#(
  parameter int CNT_WIDTH      = 32,
  parameter int REFRESH_CYCLES = 4096
) (
  input  logic                 user_clk,
  input  logic                 reset,
  input  logic [31:0]          fifo_thresholds,
  input  logic                 channel_up,
  input  logic [15:0]          rx_fifo_count,
  output logic                 nfc_tvalid,
  output logic [15:0]          nfc_tdata,
  input  logic                 nfc_tready,
  output logic                 xoff_active,
  output logic                 config_error,
  output logic [CNT_WIDTH-1:0] xoff_count,
  output logic [CNT_WIDTH-1:0] xoff_cycles
);

  localparam int TMR_W = (REFRESH_CYCLES > 0) ? $clog2(REFRESH_CYCLES + 1) : 1;
  localparam bit REFRESH_EN = (REFRESH_CYCLES != 0);
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);

  logic [15:0]      cnt_p0;
  nfc_thr_t         thr_p0;
  logic             cfg_err_p0;
  nfc_state_e       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             xoff_active_q, xoff_active_d;
  logic             hit_full, hit_empty, refresh_due;

  // Stage p0: register occupancy and thresholds; reset thresholds to a
  // value that cannot trigger XOFF before real thresholds are captured.
  always_ff @(posedge user_clk or posedge reset) begin
    if (reset) begin
      cnt_p0     <= '0;
      thr_p0     <= '{prog_full: 16'hFFFF, prog_empty: 16'h0000};
      cfg_err_p0 <= 1'b0;
    end else begin
      cnt_p0            <= rx_fifo_count;
      thr_p0.prog_full  <= fifo_thresholds[PROG_FULL_MSB:PROG_FULL_LSB];
      thr_p0.prog_empty <= fifo_thresholds[PROG_EMPTY_MSB:PROG_EMPTY_LSB];
      cfg_err_p0        <= fifo_thresholds[PROG_EMPTY_MSB:PROG_EMPTY_LSB] >=
                           fifo_thresholds[PROG_FULL_MSB:PROG_FULL_LSB];
    end
  end

  assign hit_full    = cnt_p0 >= thr_p0.prog_full;
  assign hit_empty   = cnt_p0 <= thr_p0.prog_empty;
  assign refresh_due = REFRESH_EN && (tmr_q == TMR_LAST);

  // Stage p1: request FSM, refresh timer and pause flag.
  always_ff @(posedge user_clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_ON;
      tmr_q         <= '0;
      xoff_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      xoff_active_q <= xoff_active_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    tmr_d         = '0;
    xoff_active_d = xoff_active_q;
    nfc_tvalid    = 1'b0;
    nfc_tdata     = NFC_XON;
    // Link down is the only case allowed to withdraw a pending request.
    if (!channel_up) begin
      state_d       = ST_ON;
      xoff_active_d = 1'b0;
    end else begin
      case (state_q)
        ST_ON: begin
          if (!cfg_err_p0 && hit_full) state_d = ST_SEND_XOFF;
        end
        ST_SEND_XOFF: begin
          if (nfc_tready) begin
            state_d       = ST_OFF;
            xoff_active_d = 1'b1;
          end
        end
        ST_OFF: begin
          if (hit_empty || cfg_err_p0) state_d = ST_SEND_XON;
          else if (refresh_due)        state_d = ST_SEND_XOFF;
          else                         tmr_d   = tmr_q + 1'b1;
        end
        ST_SEND_XON: begin
          if (nfc_tready) begin
            state_d       = ST_ON;
            xoff_active_d = 1'b0;
          end
        end
        default: state_d = ST_ON;
      endcase
    end
    if (state_q == ST_SEND_XOFF) begin
      nfc_tvalid = 1'b1;
      nfc_tdata  = NFC_XOFF;
    end else if (state_q == ST_SEND_XON) begin
      nfc_tvalid = 1'b1;
      nfc_tdata  = NFC_XON;
    end
  end

  assign xoff_active  = xoff_active_q;
  assign config_error = cfg_err_p0;

`ifdef AURORA_HLS_NFC_STATUS_EN
  logic xoff_acc;
  assign xoff_acc = (state_q == ST_SEND_XOFF) && nfc_tready && channel_up;

  aurora_hls_sat_counter #(.DATA_W(CNT_WIDTH)) u_xoff_count (
    .clk   (user_clk),
    .rst   (reset),
    .en    (xoff_acc),
    .count (xoff_count)
  );

  aurora_hls_sat_counter #(.DATA_W(CNT_WIDTH)) u_xoff_cycles (
    .clk   (user_clk),
    .rst   (reset),
    .en    (xoff_active_q),
    .count (xoff_cycles)
  );
`else
  assign xoff_count  = '0;
  assign xoff_cycles = '0;
`endif

endmodule

// File: tb/tb_aurora_hls_nfc.sv
// Scoreboard bench for aurora_hls_nfc: expected NFC codes are queued by the
// stimulus and popped by a monitor on every accepted handshake.
module tb_aurora_hls_nfc;

`ifdef AURORA_HLS_NFC_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic        user_clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] fifo_thresholds = {16'd48, 16'd16};
  logic        channel_up = 1'b1;
  logic [15:0] rx_fifo_count = 16'd0;
  logic        nfc_tvalid;
  logic [15:0] nfc_tdata;
  logic        nfc_tready = 1'b1;
  logic        xoff_active;
  logic        config_error;
  logic [31:0] xoff_count;
  logic [31:0] xoff_cycles;

  aurora_hls_nfc #(.CNT_WIDTH(32), .REFRESH_CYCLES(8)) dut (
    .user_clk        (user_clk),
    .reset           (reset),
    .fifo_thresholds (fifo_thresholds),
    .channel_up      (channel_up),
    .rx_fifo_count   (rx_fifo_count),
    .nfc_tvalid      (nfc_tvalid),
    .nfc_tdata       (nfc_tdata),
    .nfc_tready      (nfc_tready),
    .xoff_active     (xoff_active),
    .config_error    (config_error),
    .xoff_count      (xoff_count),
    .xoff_cycles     (xoff_cycles)
  );

  always #5 user_clk = ~user_clk;

  int          checks = 0;
  int          errors = 0;
  int          accepts = 0;
  int          exp_accepts = 0;
  int          exp_xoff_cnt = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge user_clk);
    #1;
  endtask

  task automatic push(input logic [15:0] code);
    exp_q.push_back(code);
    exp_accepts++;
  endtask

  function automatic logic [31:0] exp_cnt(input int v);
    return STATUS_EN ? 32'(v) : 32'd0;
  endfunction

  // Monitor: every handshake the core will accept must match the next queued code.
  always @(negedge user_clk) begin
    if (!reset && nfc_tvalid && nfc_tready) begin
      accepts++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_request: got tdata %0h expected no request at %0t", nfc_tdata, $time);
      end else begin
        check("sb_tdata", {16'd0, nfc_tdata}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] vals [10];
    vals = '{16'd50, 16'd30, 16'd60, 16'd17, 16'd5, 16'd48, 16'd16, 16'd70, 16'd40, 16'd10};

    // Reset state
    step(); step();
    check("rst_tvalid", nfc_tvalid, 0);
    check("rst_tdata", nfc_tdata, 0);
    check("rst_xoff_active", xoff_active, 0);
    check("rst_config_error", config_error, 0);
    check("rst_xoff_count", xoff_count, 0);
    check("rst_xoff_cycles", xoff_cycles, 0);
    reset = 1'b0;

    // Ramp up to prog_full: request appears 2 cycles after count=48
    for (int v = 0; v < 48; v += 8) begin
      rx_fifo_count = 16'(v);
      step();
      check("ramp_no_req", nfc_tvalid, 0);
    end
    check("cfg_ok", config_error, 0);
    rx_fifo_count = 16'd48;
    push(16'h0001);
    step();
    check("xoff_lat1", nfc_tvalid, 0);
    step();
    check("xoff_lat2_tvalid", nfc_tvalid, 1);
    check("xoff_lat2_tdata", nfc_tdata, 16'h0001);
    step();
    exp_xoff_cnt++;
    check("xoff_acc_tvalid", nfc_tvalid, 0);
    check("xoff_acc_active", xoff_active, 1);

    // Fall through the hysteresis band, then XON at prog_empty
    rx_fifo_count = 16'd30;
    step();
    check("band30_no_req", nfc_tvalid, 0);
    rx_fifo_count = 16'd17;
    step();
    check("band17_no_req", nfc_tvalid, 0);
    rx_fifo_count = 16'd16;
    push(16'h0000);
    step();
    check("xon_lat1", nfc_tvalid, 0);
    step();
    check("xon_tvalid", nfc_tvalid, 1);
    check("xon_tdata", nfc_tdata, 16'h0000);
    check("xon_still_paused", xoff_active, 1);
    step();
    check("xon_acc_tvalid", nfc_tvalid, 0);
    check("xon_acc_active", xoff_active, 0);
    check("p1_xoff_count", xoff_count, exp_cnt(exp_xoff_cnt));
    check("p1_xoff_cycles", xoff_cycles, exp_cnt(5));

    // Hysteresis from ON: below prog_full gives nothing
    rx_fifo_count = 16'd40;
    for (int i = 0; i < 4; i++) begin
      step();
      check("band40_no_req", nfc_tvalid, 0);
    end

    // Back-pressure: tvalid/tdata hold while count moves around
    nfc_tready = 1'b0;
    rx_fifo_count = 16'd50;
    push(16'h0001);
    step();
    check("bp_lat1", nfc_tvalid, 0);
    step();
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_tvalid", nfc_tvalid, 1);
      check("bp_hold_tdata", nfc_tdata, 16'h0001);
      rx_fifo_count = vals[i];
      if (i == 9) push(16'h0000);
      step();
    end
    nfc_tready = 1'b1;
    step();
    exp_xoff_cnt++;
    check("bp_acc_active", xoff_active, 1);
    check("bp_acc_tvalid", nfc_tvalid, 0);
    step();
    check("bp_xon_tvalid", nfc_tvalid, 1);
    check("bp_xon_tdata", nfc_tdata, 16'h0000);
    step();
    check("bp_xon_done", xoff_active, 0);

    // Refresh: 8 OFF cycles between XOFF acceptances while count stays high
    rx_fifo_count = 16'd60;
    push(16'h0001);
    step();
    check("rf_lat1", nfc_tvalid, 0);
    step();
    check("rf_first_tvalid", nfc_tvalid, 1);
    for (int r = 0; r < 3; r++) begin
      step();
      exp_xoff_cnt++;
      check("rf_active", xoff_active, 1);
      check("rf_xoff_count", xoff_count, exp_cnt(exp_xoff_cnt));
      push(16'h0001);
      for (int k = 0; k < 8; k++) begin
        check("rf_gap_no_req", nfc_tvalid, 0);
        step();
      end
      check("rf_resend_tvalid", nfc_tvalid, 1);
      check("rf_resend_tdata", nfc_tdata, 16'h0001);
    end
    rx_fifo_count = 16'd10;
    push(16'h0000);
    step();
    exp_xoff_cnt++;
    check("rf_last_active", xoff_active, 1);
    check("rf_last_count", xoff_count, exp_cnt(exp_xoff_cnt));
    step();
    check("rf_xon_tdata", nfc_tdata, 16'h0000);
    check("rf_xon_tvalid", nfc_tvalid, 1);
    step();
    check("rf_xon_done", xoff_active, 0);

    // Unusable thresholds block XOFF
    fifo_thresholds = {16'd16, 16'd16};
    rx_fifo_count = 16'd100;
    check("cfg_before_edge", config_error, 0);
    step();
    check("cfg_err_set", config_error, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("cfg_no_req", nfc_tvalid, 0);
    end
    fifo_thresholds = {16'd48, 16'd16};
    rx_fifo_count = 16'd10;
    step();
    check("cfg_err_clear", config_error, 0);
    step();

    // Link drop withdraws a pending XOFF and clears the pause flag
    nfc_tready = 1'b0;
    rx_fifo_count = 16'd60;
    step();
    step();
    check("cu_pending", nfc_tvalid, 1);
    step();
    check("cu_still_pending", nfc_tvalid, 1);
    channel_up = 1'b0;
    step();
    check("cu_drop_tvalid", nfc_tvalid, 0);
    check("cu_drop_active", xoff_active, 0);
    step();
    check("cu_down_no_req", nfc_tvalid, 0);
    channel_up = 1'b1;
    nfc_tready = 1'b1;
    push(16'h0001);
    step();
    check("cu_up_req", nfc_tvalid, 1);
    step();
    exp_xoff_cnt++;
    check("cu_up_active", xoff_active, 1);
    check("cu_up_count", xoff_count, exp_cnt(exp_xoff_cnt));
    channel_up = 1'b0;
    step();
    check("cu_drop_off_active", xoff_active, 0);
    check("cu_drop_off_tvalid", nfc_tvalid, 0);

    // Asynchronous reset in the middle of a pending XOFF
    channel_up = 1'b1;
    nfc_tready = 1'b0;
    step();
    check("ar_pending", nfc_tvalid, 1);
    #2 reset = 1'b1;
    #1;
    check("ar_tvalid", nfc_tvalid, 0);
    check("ar_active", xoff_active, 0);
    check("ar_xoff_count", xoff_count, 0);
    rx_fifo_count = 16'd0;
    step();
    reset = 1'b0;
    step();
    step();
    check("ar_after_tvalid", nfc_tvalid, 0);

    check("sb_queue_empty", exp_q.size(), 0);
    check("sb_accepts", accepts, exp_accepts);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
